id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage feeding the execute-stage ALU.
- Registers decoded operands and control, and applies EX/MEM and MEM/WB forwarding.
- Drives the ALU X, Y and CONTROL inputs.
- Detects load-use hazards and inserts bubbles.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register address width

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
STALL  in  1  hold stage contents
FLUSH  in  1  replace captured instruction with bubble
ID_VALID  in  1  decode slot holds a real instruction
ID_PC  in  DATA_W  instruction PC
ID_RS1_DATA, ID_RS2_DATA  in  DATA_W  register-file read data
ID_IMM  in  DATA_W  sign-extended immediate
ID_RS1, ID_RS2, ID_RD  in  REG_AW  register addresses
ID_ALU_CONTROL  in  4  ALU op code
ID_SRC_A  in  1  0=rs1, 1=PC
ID_SRC_B  in  1  0=rs2, 1=imm
ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE  in  1  control flags
MEM_RD, WB_RD  in  REG_AW  destination in EX/MEM and MEM/WB
MEM_REG_WRITE, WB_REG_WRITE  in  1  write enables of those stages
MEM_RESULT, WB_RESULT  in  DATA_W  forwarded values
X, Y  out  DATA_W  ALU operands
CONTROL  out  4  ALU op code
EX_VALID, EX_REG_WRITE, EX_MEM_READ, EX_MEM_WRITE  out  1  registered flags
EX_RD  out  REG_AW  registered destination
EX_PC  out  DATA_W  registered PC
EX_STORE_DATA  out  DATA_W  forwarded rs2, for stores
LOAD_USE_STALL  out  1  combinational hazard request to IF/ID

Behaviour:
- Reset (RST_N low, asynchronous): all registers 0, so EX_VALID=0, CONTROL=4'b0000, all flags 0, X=Y=0. LOAD_USE_STALL=0.
- Update priority at each rising edge: FLUSH > STALL > LOAD_USE_STALL > normal capture.
  - FLUSH: load bubble. Bubble = VALID=0, REG_WRITE=MEM_READ=MEM_WRITE=0, CONTROL=4'b0000, data fields 0.
  - STALL: all registers hold, except stored rs1/rs2 data, which are rewritten with their currently forwarded values. This prevents loss of a WB forward that retires during the stall.
  - LOAD_USE_STALL (no FLUSH/STALL): load bubble; upstream holds IF/ID.
  - Otherwise: capture all ID_* inputs.
- Forwarding, combinational on the stored rs addresses, evaluated per operand:
  - EX/MEM match (MEM_REG_WRITE, MEM_RD==rs, rs!=0) selects MEM_RESULT.
  - Else MEM/WB match (same rules) selects WB_RESULT.
  - Else stored register data.
  - x0 is never forwarded. EX/MEM wins when both stages match.
- Operand select:
  - X = PC if SRC_A, else forwarded rs1.
  - Y = imm if SRC_B, else forwarded rs2.
  - EX_STORE_DATA is always forwarded rs2.
- LOAD_USE_STALL = EX_VALID & EX_MEM_READ & ID_VALID & (EX_RD!=0) & (EX_RD==ID_RS1 | EX_RD==ID_RS2). Both rs fields are compared regardless of instruction format; occasional false stalls are accepted.
- Latency: one cycle from ID capture to X/Y/CONTROL valid. Forward paths add no latency.
- Bubble passing through the ALU: computes 0+0, writes nothing.
- Reset mid-stall: registers clear immediately, stall state is discarded.

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: forwarding as above.
- Undefined:
  - Forward muxes are removed; operands come from stored register data only.
  - LOAD_USE_STALL widens to any valid EX instruction with EX_REG_WRITE and a matching nonzero rd.
  - MEM_*/WB_* inputs are ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU op constants: ALU_ADD=4'b0000, ALU_OR=4'b0001, ALU_AND=4'b0010, ALU_BNE=4'b0011, ALU_SLT=4'b0100, ALU_SUB=4'b0111, ALU_SLL=4'b1000, ALU_XOR=4'b1001, ALU_SRL=4'b1010, ALU_BGE=4'b1011, ALU_LUI=4'b1100, ALU_SLTU=4'b1101, ALU_SRA=4'b1110, ALU_BEQ=4'b1111.
  - Packed struct id_ex_ctrl_t bundling the control flags and rd.
  - Enum fwd_sel_t {FWD_REG, FWD_MEM, FWD_WB}.
- One sub-module, forward_mux, instantiated twice (rs1, rs2): inputs rs address, stored data, MEM/WB triplets; outputs value and fwd_sel_t.

Test Plan:
- Reset then capture ADD (rs1 data=5, rs2 data=7, CONTROL=0000) -> next cycle X=5, Y=7, CONTROL=0000, EX_VALID=1.
- EX/MEM and MEM/WB both write x3 (MEM_RESULT=0xAA, WB_RESULT=0xBB), stored rs1=x3 -> X=0xAA; with MEM_REG_WRITE=0 -> X=0xBB; with rs1=x0 -> X=stored data.
- LW to x5 in EX, ID instruction reads rs2=x5 -> LOAD_USE_STALL=1, next cycle EX_VALID=0, CONTROL=0000, REG_WRITE=0.
- STALL held 2 cycles while WB_RESULT=0x1234 for rs1 retires after cycle 1 -> X stays 0x1234 throughout.
- FLUSH and STALL asserted together -> bubble loaded; AUIPC with PC=0x100, imm=0x2000, SRC_A=1, SRC_B=1 -> X=0x100, Y=0x2000.
- Assert RST_N low mid-cycle with EX_VALID=1 -> all outputs 0 before the next clock edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the ID/EX stage and its forwarding muxes.
//
// Contents:
//   DEF_DATA_W / DEF_REG_AW : default datapath and register-address widths
//   alu_op_t                : ALU operation codes driven on the ALU CONTROL input
//   fwd_sel_t               : which source an operand forward mux picked
//   id_ex_ctrl_t            : control flags and destination register carried by ID/EX
package cpu_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_OR   = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_BNE  = 4'b0011,
        ALU_SLT  = 4'b0100,
        ALU_SUB  = 4'b0111,
        ALU_SLL  = 4'b1000,
        ALU_XOR  = 4'b1001,
        ALU_SRL  = 4'b1010,
        ALU_BGE  = 4'b1011,
        ALU_LUI  = 4'b1100,
        ALU_SLTU = 4'b1101,
        ALU_SRA  = 4'b1110,
        ALU_BEQ  = 4'b1111
    } alu_op_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    // An all-zero value of this struct is a bubble: no writes, ALU op ADD.
    typedef struct packed {
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  src_a;
        logic                  src_b;
        logic [3:0]            alu_control;
        logic [DEF_REG_AW-1:0] rd;
    } id_ex_ctrl_t;

endpackage

// File: rtl/forward_mux.sv
// Operand forwarding mux for one source register of the instruction held in ID/EX.
//
// Ports:
//   rs            in  : source register address held in ID/EX
//   reg_data      in  : register-file data captured with that instruction
//   mem_reg_write in  : EX/MEM stage will write a register
//   mem_rd        in  : EX/MEM destination register
//   mem_result    in  : EX/MEM result value
//   wb_reg_write  in  : MEM/WB stage will write a register
//   wb_rd         in  : MEM/WB destination register
//   wb_result     in  : MEM/WB result value
//   value         out : operand after forwarding
//   sel           out : which source was chosen
module forward_mux
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [DATA_W-1:0] reg_data,
    input  logic              mem_reg_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              wb_reg_write,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] value,
    output fwd_sel_t          sel
);

    // The younger EX/MEM result is checked first so it wins when both stages
    // target the same register; x0 is hardwired zero and never forwarded.
    always_comb begin
        sel   = FWD_REG;
        value = reg_data;
        if (rs != '0 && mem_reg_write && mem_rd == rs) begin
            sel   = FWD_MEM;
            value = mem_result;
        end else if (rs != '0 && wb_reg_write && wb_rd == rs) begin
            sel   = FWD_WB;
            value = wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register and ALU operand-select stage.
//
// Registers the decoded instruction, forwards EX/MEM and MEM/WB results into
// the stored source operands, drives the ALU x/y/control inputs and raises a
// combinational load-use hazard request towards IF/ID.
//
// Build option: define ID_EX_FORWARD_EN to enable EX/MEM and MEM/WB forwarding.
// Without it, operands come only from the stored register data, the mem_* and
// wb_* inputs are ignored, and load_use_stall fires for any register-writing
// instruction in EX whose rd matches a source of the decoding instruction.
//
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   stall                          : hold stage (source data refreshed from forwards)
//   flush                          : load a bubble
//   id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
//   id_rs1, id_rs2, id_rd, id_alu_control, id_src_a, id_src_b,
//   id_reg_write, id_mem_read, id_mem_write : decoded instruction
//   mem_rd, mem_reg_write, mem_result       : EX/MEM forward source
//   wb_rd, wb_reg_write, wb_result          : MEM/WB forward source
//   x, y, control                  : ALU operands and op code
//   ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd, ex_pc : registered state
//   ex_store_data                  : forwarded rs2 for stores
//   load_use_stall                 : hazard request to IF/ID
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs1_data,
    input  logic [DATA_W-1:0] id_rs2_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [3:0]        id_alu_control,
    input  logic              id_src_a,
    input  logic              id_src_b,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              mem_reg_write,
    input  logic              wb_reg_write,
    input  logic [DATA_W-1:0] mem_result,
    input  logic [DATA_W-1:0] wb_result,
    output logic [DATA_W-1:0] x,
    output logic [DATA_W-1:0] y,
    output logic [3:0]        control,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic [REG_AW-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              load_use_stall
);

    logic              valid_q;
    id_ex_ctrl_t       ctrl_q;
    logic [DATA_W-1:0] pc_q;
    logic [DATA_W-1:0] rs1_data_q;
    logic [DATA_W-1:0] rs2_data_q;
    logic [DATA_W-1:0] imm_q;
    logic [REG_AW-1:0] rs1_q;
    logic [REG_AW-1:0] rs2_q;

    logic [DATA_W-1:0] rs1_fwd;
    logic [DATA_W-1:0] rs2_fwd;
    fwd_sel_t          rs1_sel;
    fwd_sel_t          rs2_sel;

    logic              f_mem_we;
    logic              f_wb_we;
    logic [REG_AW-1:0] f_mem_rd;
    logic [REG_AW-1:0] f_wb_rd;
    logic [DATA_W-1:0] f_mem_result;
    logic [DATA_W-1:0] f_wb_result;
    logic              hazard_kind;

`ifdef ID_EX_FORWARD_EN
    // Later stages feed the forward muxes; only a load in EX is a hazard
    // because every other result reaches us through the EX/MEM forward.
    assign f_mem_we     = mem_reg_write;
    assign f_wb_we      = wb_reg_write;
    assign f_mem_rd     = mem_rd;
    assign f_wb_rd      = wb_rd;
    assign f_mem_result = mem_result;
    assign f_wb_result  = wb_result;
    assign hazard_kind  = ctrl_q.mem_read;
`else
    // Forward sources tied off so the muxes collapse to the stored data;
    // any register write still in flight must then be waited out.
    logic unused_fwd_inputs;
    assign f_mem_we     = 1'b0;
    assign f_wb_we      = 1'b0;
    assign f_mem_rd     = '0;
    assign f_wb_rd      = '0;
    assign f_mem_result = '0;
    assign f_wb_result  = '0;
    assign hazard_kind  = ctrl_q.reg_write;
    assign unused_fwd_inputs = ^{mem_rd, wb_rd, mem_reg_write, wb_reg_write,
                                 mem_result, wb_result};
`endif

    forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs            (rs1_q),
        .reg_data      (rs1_data_q),
        .mem_reg_write (f_mem_we),
        .mem_rd        (f_mem_rd),
        .mem_result    (f_mem_result),
        .wb_reg_write  (f_wb_we),
        .wb_rd         (f_wb_rd),
        .wb_result     (f_wb_result),
        .value         (rs1_fwd),
        .sel           (rs1_sel)
    );

    forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs            (rs2_q),
        .reg_data      (rs2_data_q),
        .mem_reg_write (f_mem_we),
        .mem_rd        (f_mem_rd),
        .mem_result    (f_mem_result),
        .wb_reg_write  (f_wb_we),
        .wb_rd         (f_wb_rd),
        .wb_result     (f_wb_result),
        .value         (rs2_fwd),
        .sel           (rs2_sel)
    );

    // Select indications are for debug visibility only.
    logic unused_sel;
    assign unused_sel = ^{rs1_sel, rs2_sel};

    // Both source fields are compared whatever the instruction format, so an
    // unused rs field can cause a harmless extra bubble.
    assign load_use_stall = valid_q & hazard_kind & id_valid & (ctrl_q.rd != '0) &
                            ((ctrl_q.rd == id_rs1) | (ctrl_q.rd == id_rs2));

    // While stalled the stored source data is overwritten with its forwarded
    // value, so a MEM/WB result that retires mid-stall is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
        end else if (flush) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
        end else if (stall) begin
            rs1_data_q <= rs1_fwd;
            rs2_data_q <= rs2_fwd;
        end else if (load_use_stall) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
        end else begin
            valid_q            <= id_valid;
            ctrl_q.reg_write   <= id_reg_write;
            ctrl_q.mem_read    <= id_mem_read;
            ctrl_q.mem_write   <= id_mem_write;
            ctrl_q.src_a       <= id_src_a;
            ctrl_q.src_b       <= id_src_b;
            ctrl_q.alu_control <= id_alu_control;
            ctrl_q.rd          <= id_rd;
            pc_q               <= id_pc;
            rs1_data_q         <= id_rs1_data;
            rs2_data_q         <= id_rs2_data;
            imm_q              <= id_imm;
            rs1_q              <= id_rs1;
            rs2_q              <= id_rs2;
        end
    end

    assign x             = ctrl_q.src_a ? pc_q  : rs1_fwd;
    assign y             = ctrl_q.src_b ? imm_q : rs2_fwd;
    assign control       = ctrl_q.alu_control;
    assign ex_store_data = rs2_fwd;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_rd         = ctrl_q.rd;
    assign ex_pc         = pc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all compared against an instruction-level reference model.
// Honours ID_EX_FORWARD_EN the same way as the design.
module tb_id_ex_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_alu_control;
    logic        id_src_a, id_src_b, id_reg_write, id_mem_read, id_mem_write;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic [31:0] mem_result, wb_result;
    logic [31:0] x, y, ex_pc, ex_store_data;
    logic [3:0]  control;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall;
    logic [4:0]  ex_rd;

    int checks = 0;
    int failures = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_control(id_alu_control),
        .id_src_a(id_src_a), .id_src_b(id_src_b), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_reg_write(mem_reg_write),
        .wb_reg_write(wb_reg_write), .mem_result(mem_result), .wb_result(wb_result),
        .x(x), .y(y), .control(control), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_pc(ex_pc),
        .ex_store_data(ex_store_data), .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    // The instruction currently sitting in EX, as the model sees it.
    typedef struct packed {
        logic        valid, reg_write, mem_read, mem_write, src_a, src_b;
        logic [3:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] pc, rs1_data, rs2_data, imm;
    } instr_t;

    instr_t inEx;

    // Value an operand register really holds right now, from the pipeline's view.
    function automatic logic [31:0] operandValue(input logic [4:0] rs, input logic [31:0] stored);
`ifdef ID_EX_FORWARD_EN
        if (rs != 5'd0 && mem_reg_write && mem_rd == rs) return mem_result;
        if (rs != 5'd0 && wb_reg_write && wb_rd == rs) return wb_result;
`endif
        return stored;
    endfunction

    function automatic logic expectHazard();
        logic producer;
`ifdef ID_EX_FORWARD_EN
        producer = inEx.mem_read;
`else
        producer = inEx.reg_write;
`endif
        return inEx.valid && producer && id_valid && inEx.rd != 5'd0 &&
               (inEx.rd == id_rs1 || inEx.rd == id_rs2);
    endfunction

    task automatic checkVal(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] a, b;
        a = operandValue(inEx.rs1, inEx.rs1_data);
        b = operandValue(inEx.rs2, inEx.rs2_data);
        checkVal({tag, ".x"}, x, inEx.src_a ? inEx.pc : a);
        checkVal({tag, ".y"}, y, inEx.src_b ? inEx.imm : b);
        checkVal({tag, ".control"}, 32'(control), 32'(inEx.op));
        checkVal({tag, ".ex_valid"}, 32'(ex_valid), 32'(inEx.valid));
        checkVal({tag, ".ex_reg_write"}, 32'(ex_reg_write), 32'(inEx.reg_write));
        checkVal({tag, ".ex_mem_read"}, 32'(ex_mem_read), 32'(inEx.mem_read));
        checkVal({tag, ".ex_mem_write"}, 32'(ex_mem_write), 32'(inEx.mem_write));
        checkVal({tag, ".ex_rd"}, 32'(ex_rd), 32'(inEx.rd));
        checkVal({tag, ".ex_pc"}, ex_pc, inEx.pc);
        checkVal({tag, ".store_data"}, ex_store_data, b);
        checkVal({tag, ".load_use_stall"}, 32'(load_use_stall), 32'(expectHazard()));
    endtask

    // What EX will hold after the coming clock edge.
    task automatic advanceModel();
        logic hazard;
        hazard = expectHazard();
        if (flush) begin
            inEx = '0;
        end else if (stall) begin
            inEx.rs1_data = operandValue(inEx.rs1, inEx.rs1_data);
            inEx.rs2_data = operandValue(inEx.rs2, inEx.rs2_data);
        end else if (hazard) begin
            inEx = '0;
        end else begin
            inEx = '{valid: id_valid, reg_write: id_reg_write, mem_read: id_mem_read,
                     mem_write: id_mem_write, src_a: id_src_a, src_b: id_src_b,
                     op: id_alu_control, rd: id_rd, rs1: id_rs1, rs2: id_rs2,
                     pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm};
        end
    endtask

    // Called one time unit after a rising edge with inputs already set.
    task automatic applyStimulus(input string tag);
        #2;
        checkOutput(tag);
        advanceModel();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        stall = 0; flush = 0; id_valid = 0;
        id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_control = ALU_ADD;
        id_src_a = 0; id_src_b = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        mem_rd = 0; wb_rd = 0; mem_reg_write = 0; wb_reg_write = 0;
        mem_result = 0; wb_result = 0;
    endtask

    initial begin
        #1000000;
        failures++;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        inEx = '0;
        clearInputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkVal("reset.x", x, 32'h0);
        checkVal("reset.y", y, 32'h0);
        checkVal("reset.control", 32'(control), 32'h0);
        checkVal("reset.ex_valid", 32'(ex_valid), 32'h0);
        checkVal("reset.load_use_stall", 32'(load_use_stall), 32'h0);
        checkOutput("reset");
        rst_n = 1'b1;

        // ADD x10 = x1 + x2 with register data 5 and 7
        id_valid = 1; id_rs1 = 1; id_rs2 = 2; id_rd = 10;
        id_rs1_data = 5; id_rs2_data = 7; id_alu_control = ALU_ADD; id_reg_write = 1;
        id_pc = 32'h40;
        applyStimulus("add");
        clearInputs();
        #1;
        checkVal("add.x", x, 32'd5);
        checkVal("add.y", y, 32'd7);
        checkVal("add.control", 32'(control), 32'(ALU_ADD));
        checkVal("add.ex_valid", 32'(ex_valid), 32'd1);

        // Instruction reading x3 while both later stages write x3
        id_valid = 1; id_rs1 = 3; id_rs1_data = 32'h11; id_rd = 4; id_reg_write = 1;
        id_alu_control = ALU_OR;
        applyStimulus("fwd_capture");
        clearInputs();
        mem_rd = 3; wb_rd = 3; mem_reg_write = 1; wb_reg_write = 1;
        mem_result = 32'hAA; wb_result = 32'hBB;
        #1;
`ifdef ID_EX_FORWARD_EN
        checkVal("fwd_both.x", x, 32'hAA);
`else
        checkVal("fwd_both.x", x, 32'h11);
`endif
        checkOutput("fwd_both");
        mem_reg_write = 0;
        #1;
`ifdef ID_EX_FORWARD_EN
        checkVal("fwd_wb.x", x, 32'hBB);
`else
        checkVal("fwd_wb.x", x, 32'h11);
`endif
        checkOutput("fwd_wb");

        // Source x0 must never pick up a forward
        id_valid = 1; id_rs1 = 0; id_rs1_data = 32'h22; id_rd = 11;
        applyStimulus("x0_capture");
        clearInputs();
        mem_rd = 0; wb_rd = 0; mem_reg_write = 1; wb_reg_write = 1;
        mem_result = 32'hAA; wb_result = 32'hBB;
        #1;
        checkVal("fwd_x0.x", x, 32'h22);
        checkOutput("fwd_x0");
        clearInputs();

        // LW x5, 4(x1) followed by an instruction reading x5 as rs2
        id_valid = 1; id_rs1 = 1; id_rd = 5; id_mem_read = 1; id_reg_write = 1;
        id_src_b = 1; id_imm = 4; id_rs1_data = 32'h1000;
        applyStimulus("lw");
        clearInputs();
        id_valid = 1; id_rs1 = 6; id_rs2 = 5; id_rd = 7; id_reg_write = 1;
        id_rs1_data = 32'h3; id_rs2_data = 32'h9; id_alu_control = ALU_SUB;
        #1;
        checkVal("lu.load_use_stall", 32'(load_use_stall), 32'd1);
        applyStimulus("lu_stall");
        #1;
        checkVal("lu_bubble.ex_valid", 32'(ex_valid), 32'd0);
        checkVal("lu_bubble.control", 32'(control), 32'(ALU_ADD));
        checkVal("lu_bubble.ex_reg_write", 32'(ex_reg_write), 32'd0);
        checkVal("lu_bubble.load_use_stall", 32'(load_use_stall), 32'd0);
        applyStimulus("lu_retry");
        clearInputs();

        // Two-cycle stall while a MEM/WB write to the x9 source retires
        id_valid = 1; id_rs1 = 9; id_rs1_data = 32'h55; id_rd = 12; id_reg_write = 1;
        id_pc = 32'h80;
        applyStimulus("stall_capture");
        clearInputs();
        stall = 1; id_pc = 32'hDEAD; id_rs1_data = 32'hBAD; id_rd = 13;
        wb_reg_write = 1; wb_rd = 9; wb_result = 32'h1234;
        applyStimulus("stall1");
        wb_reg_write = 0;
        #1;
`ifdef ID_EX_FORWARD_EN
        checkVal("stall1.x", x, 32'h1234);
`else
        checkVal("stall1.x", x, 32'h55);
`endif
        applyStimulus("stall2");
        stall = 0;
        #1;
`ifdef ID_EX_FORWARD_EN
        checkVal("stall2.x", x, 32'h1234);
`else
        checkVal("stall2.x", x, 32'h55);
`endif
        checkVal("stall2.ex_pc", ex_pc, 32'h80);
        clearInputs();

        // FLUSH wins over STALL, then AUIPC uses PC and immediate
        flush = 1; stall = 1; id_valid = 1; id_rd = 14; id_reg_write = 1; id_pc = 32'h77;
        applyStimulus("flush_stall");
        #1;
        checkVal("flush.ex_valid", 32'(ex_valid), 32'd0);
        checkVal("flush.x", x, 32'h0);
        checkVal("flush.y", y, 32'h0);
        clearInputs();
        id_valid = 1; id_pc = 32'h100; id_imm = 32'h2000; id_src_a = 1; id_src_b = 1;
        id_rd = 8; id_reg_write = 1;
        applyStimulus("auipc");
        clearInputs();
        #1;
        checkVal("auipc.x", x, 32'h100);
        checkVal("auipc.y", y, 32'h2000);

        // Asynchronous reset between clock edges
        #1;
        rst_n = 1'b0;
        inEx = '0;
        #1;
        checkVal("async_reset.ex_valid", 32'(ex_valid), 32'd0);
        checkVal("async_reset.x", x, 32'h0);
        checkVal("async_reset.y", y, 32'h0);
        checkVal("async_reset.ex_pc", ex_pc, 32'h0);
        checkOutput("async_reset");
        #1;
        rst_n = 1'b1;
        applyStimulus("post_reset");

        // Random traffic with a small register window to provoke matches
        for (int i = 0; i < 400; i++) begin
            flush          = ($urandom_range(0, 15) == 0);
            stall          = ($urandom_range(0, 5) == 0);
            id_valid       = ($urandom_range(0, 3) != 0);
            id_pc          = $urandom;
            id_rs1_data    = $urandom;
            id_rs2_data    = $urandom;
            id_imm         = $urandom;
            id_rs1         = 5'($urandom_range(0, 7));
            id_rs2         = 5'($urandom_range(0, 7));
            id_rd          = 5'($urandom_range(0, 7));
            id_alu_control = 4'($urandom);
            id_src_a       = 1'($urandom);
            id_src_b       = 1'($urandom);
            id_reg_write   = 1'($urandom);
            id_mem_read    = ($urandom_range(0, 2) == 0);
            id_mem_write   = 1'($urandom);
            mem_rd         = 5'($urandom_range(0, 7));
            wb_rd          = 5'($urandom_range(0, 7));
            mem_reg_write  = 1'($urandom);
            wb_reg_write   = 1'($urandom);
            mem_result     = $urandom;
            wb_result      = $urandom;
            applyStimulus("random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
